// File: rtl/imm_pkg.sv
// Immediate-mode encodings and shared helpers for the pipelined immediate extender.
package imm_pkg;

  localparam logic [2:0] IMM_DP8    = 3'b000;
  localparam logic [2:0] IMM_MEM12  = 3'b001;
  localparam logic [2:0] IMM_BR24   = 3'b010;
  localparam logic [2:0] IMM_ROT8   = 3'b011;
  localparam logic [2:0] IMM_HALF8  = 3'b100;
  localparam logic [2:0] IMM_SMEM12 = 3'b101;
  localparam logic [2:0] IMM_RSVD6  = 3'b110;
  localparam logic [2:0] IMM_RSVD7  = 3'b111;

  // Rotate right by concatenating the word with itself and keeping the low half.
  function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] amt);
    return 32'({v, v} >> amt);
  endfunction

endpackage

// File: rtl/imm_rotator.sv
// Data-processing rotated imm8: ror32(zext(imm8), 2*rot4) with shifter carry-out.
module imm_rotator
  import imm_pkg::*;
(
  input  logic [7:0]  imm8_i,
  input  logic [3:0]  rot4_i,
  input  logic        carry_i,
  output logic [31:0] result_o,
  output logic        carry_o
);

  always_comb begin
    result_o = ror32({24'h000000, imm8_i}, {rot4_i, 1'b0});
    // A zero rotate leaves the CPSR carry untouched.
    carry_o  = (rot4_i == 4'd0) ? carry_i : result_o[31];
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready immediate extender: stage 1 captures the instruction
// fields, stage 2 registers the decoded, width-extended immediate.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BR_SHIFT    = 2,
  parameter int unsigned ERR_ON_RSVD = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [23:0]     theData,
  input  logic [2:0]      ImmSrc,
  input  logic            carry_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ExtImm,
  output logic            carry_out,
  output logic            imm_err
);

  logic            s1_valid_q, s1_valid_d;
  logic [23:0]     s1_data_q;
  logic [2:0]      s1_src_q;
  logic            s1_cin_q;
  logic [3:0]      s1_rot_q;

  logic            s2_valid_q, s2_valid_d;
  logic [XLEN-1:0] ext_q, ext_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;

  logic            s2_adv, s1_adv, in_xfer;
  logic [31:0]     rot_res;
  logic            rot_carry;
  logic [31:0]     res32;
  logic            sext;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_xfer  = in_valid && in_ready;

  always_comb begin
    s1_valid_d = in_xfer || (s1_valid_q && !s2_adv);
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  imm_rotator u_rot (
    .imm8_i   (s1_data_q[7:0]),
    .rot4_i   (s1_rot_q),
    .carry_i  (s1_cin_q),
    .result_o (rot_res),
    .carry_o  (rot_carry)
  );

  always_comb begin
    res32  = '0;
    sext   = 1'b0;
    cout_d = s1_cin_q;
    err_d  = 1'b0;
    case (s1_src_q)
      IMM_DP8:    res32 = {24'h000000, s1_data_q[7:0]};
      IMM_MEM12:  res32 = {20'h00000, s1_data_q[11:0]};
      IMM_BR24: begin
        res32 = {{8{s1_data_q[23]}}, s1_data_q} << BR_SHIFT;
        sext  = 1'b1;
      end
      IMM_ROT8: begin
        res32  = rot_res;
        cout_d = rot_carry;
      end
      IMM_HALF8:  res32 = {24'h000000, s1_data_q[11:8], s1_data_q[3:0]};
      IMM_SMEM12: begin
        res32 = {{20{s1_data_q[11]}}, s1_data_q[11:0]};
        sext  = 1'b1;
      end
      default:    err_d = (ERR_ON_RSVD != 0);
    endcase
    if (sext) ext_d = XLEN'($signed(res32));
    else      ext_d = XLEN'(res32);
  end

  // Stage-1 payload needs no reset: it is only observed behind s1_valid_q.
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      s1_data_q <= theData;
      s1_src_q  <= ImmSrc;
      s1_cin_q  <= carry_in;
      s1_rot_q  <= theData[11:8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      ext_q      <= '0;
      cout_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_adv) begin
        ext_q  <= ext_d;
        cout_q <= cout_d;
        err_q  <= err_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign ExtImm    = ext_q;
  assign carry_out = cout_q;
  assign imm_err   = err_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: a 32-bit/err-on-reserved instance and a 64-bit/silent
// instance share stimulus and are checked against a queue-based reference model.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready, carry_in;
  logic [23:0] theData;
  logic [2:0]  ImmSrc;

  logic        in_ready_a, out_valid_a, carry_out_a, imm_err_a;
  logic [31:0] ext_a;
  logic        in_ready_b, out_valid_b, carry_out_b, imm_err_b;
  logic [63:0] ext_b;

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32), .BR_SHIFT(2), .ERR_ON_RSVD(1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
    .theData(theData), .ImmSrc(ImmSrc), .carry_in(carry_in), .out_valid(out_valid_a),
    .out_ready(out_ready), .ExtImm(ext_a), .carry_out(carry_out_a), .imm_err(imm_err_a)
  );

  imm_extend_pipe #(.XLEN(64), .BR_SHIFT(2), .ERR_ON_RSVD(0)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .theData(theData), .ImmSrc(ImmSrc), .carry_in(carry_in), .out_valid(out_valid_b),
    .out_ready(out_ready), .ExtImm(ext_b), .carry_out(carry_out_b), .imm_err(imm_err_b)
  );

  typedef struct {
    logic [23:0] d;
    logic [2:0]  src;
    logic        cin;
    int unsigned t;
  } item_t;

  item_t       q[$];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  bit          just_reset = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: ARM immediate rules in plain arithmetic, branch shift of 2.
  function automatic logic [63:0] model_ext(input item_t it, input bit wide);
    longint      v;
    logic [31:0] w;
    case (it.src)
      3'd0: v = longint'(it.d[7:0]);
      3'd1: v = longint'(it.d[11:0]);
      3'd2: begin
        v = longint'(it.d);
        if (it.d[23]) v = v - 16777216;
        v = v * 4;
      end
      3'd3: begin
        w = {24'h000000, it.d[7:0]};
        for (int unsigned i = 0; i < 2 * it.d[11:8]; i++) w = {w[0], w[31:1]};
        v = longint'({32'h00000000, w});
      end
      3'd4: v = longint'(it.d[11:8]) * 16 + longint'(it.d[3:0]);
      3'd5: begin
        v = longint'(it.d[11:0]);
        if (it.d[11]) v = v - 4096;
      end
      default: v = 0;
    endcase
    if (!wide) v = v & 64'h00000000FFFFFFFF;
    return 64'(v);
  endfunction

  function automatic logic model_cout(input item_t it);
    logic [63:0] r;
    r = model_ext(it, 1'b0);
    if (it.src == 3'd3 && it.d[11:8] != 4'd0) return r[31];
    return it.cin;
  endfunction

  task automatic step(output bit acc);
    bit    exp_ov, exp_ir, out_x;
    item_t h, n;
    #3;
    exp_ov = (q.size() > 0) && (cyc - q[0].t >= 2);
    exp_ir = !(q.size() == 2 && !out_ready);
    chk("in_ready_a", {63'd0, in_ready_a}, {63'd0, exp_ir});
    chk("in_ready_b", {63'd0, in_ready_b}, {63'd0, exp_ir});
    chk("out_valid_a", {63'd0, out_valid_a}, {63'd0, exp_ov});
    chk("out_valid_b", {63'd0, out_valid_b}, {63'd0, exp_ov});
    if (exp_ov) begin
      h = q[0];
      chk("ext_a", {32'd0, ext_a}, model_ext(h, 1'b0));
      chk("ext_b", ext_b, model_ext(h, 1'b1));
      chk("cout_a", {63'd0, carry_out_a}, {63'd0, model_cout(h)});
      chk("cout_b", {63'd0, carry_out_b}, {63'd0, model_cout(h)});
      chk("err_a", {63'd0, imm_err_a}, {63'd0, h.src[2] & h.src[1]});
      chk("err_b", {63'd0, imm_err_b}, 64'd0);
    end
    if (just_reset) begin
      chk("rst_ext_a", {32'd0, ext_a}, 64'd0);
      chk("rst_ext_b", ext_b, 64'd0);
      chk("rst_cout_a", {63'd0, carry_out_a}, 64'd0);
      chk("rst_err_a", {63'd0, imm_err_a}, 64'd0);
      just_reset = 1'b0;
    end
    acc   = in_valid && exp_ir;
    out_x = exp_ov && out_ready;
    if (reset || flush) begin
      q.delete();
    end else begin
      if (out_x) void'(q.pop_front());
      if (acc) begin
        n.d = theData; n.src = ImmSrc; n.cin = carry_in; n.t = cyc;
        q.push_back(n);
      end
    end
    if (reset) just_reset = 1'b1;
    if (reset || flush) acc = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic rand_item();
    theData  = 24'($urandom);
    ImmSrc   = 3'($urandom_range(0, 7));
    carry_in = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [23:0] d, input logic [2:0] s, input logic c);
    bit acc;
    bit done;
    done     = 1'b0;
    in_valid = 1'b1; theData = d; ImmSrc = s; carry_in = c;
    for (int i = 0; i < 20 && !done; i++) begin
      step(acc);
      done = acc;
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    logic [23:0] dd [10];
    logic [2:0]  ss [10];
    logic        cc [10];
    bit          acc;
    int          n;

    dd = '{24'h0004FF, 24'h0000AB, 24'hFFFFFE, 24'h000010, 24'h000A05,
           24'h000800, 24'h123456, 24'h000ABC, 24'hFFF123, 24'h000F01};
    ss = '{3'd3, 3'd3, 3'd2, 3'd2, 3'd4, 3'd5, 3'd7, 3'd0, 3'd1, 3'd3};
    cc = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    theData = '0; ImmSrc = '0; carry_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    just_reset = 1'b1;

    for (int i = 0; i < 10; i++) send(dd[i], ss[i], cc[i]);
    repeat (4) step(acc);

    // Eight back-to-back items with the consumer stalled for cycles 3-5.
    n = 0;
    in_valid = 1'b1;
    rand_item();
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      step(acc);
      if (acc) begin
        n++;
        if (n == 8) in_valid = 1'b0;
        else rand_item();
      end
    end
    if (n != 8) chk("burst_count", 64'(n), 64'd8);

    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      rand_item();
      step(acc);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step(acc);

    // Fill both stages, then flush with a new input on the same cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin rand_item(); step(acc); end
    flush = 1'b1;
    rand_item();
    step(acc);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step(acc);

    // Reset with items in flight.
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin rand_item(); step(acc); end
    reset = 1'b1;
    rand_item();
    step(acc);
    reset = 1'b0; in_valid = 1'b0;
    repeat (3) step(acc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
